axi_lite_master_if: RTL and testbench

AXI4-Lite master that turns a simple single-word command/response interface from user logic into AXI4-Lite read and write transactions. It is the initiator counterpart to the team's 4-register AXI-Lite slave and drives any AXI4-Lite slave port. Only one transaction is outstanding at a time.

---
 rtl/axi_lite_master_if.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_master_if.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_if
//
// Purpose:
//   AXI4-Lite master that converts a single-word command/response interface
//   from user logic into AXI4-Lite read and write transactions. Only one
//   transaction is in flight at a time. Commands are accepted only in IDLE.
//   Each transaction ends with a one-cycle rsp_valid pulse that coincides with
//   the return to IDLE, so a new command can be accepted in that same cycle.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN    clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready        command handshake; cmd_ready == (FSM in IDLE)
//   cmd_write                    1 = write, 0 = read
//   cmd_addr/cmd_wdata/cmd_wstrb command payload, registered at accept
//   rsp_valid                    one-cycle completion pulse
//   rsp_rdata / rsp_resp         read data (0 for writes) and BRESP/RRESP
//   M_AXI_AW_* / M_AXI_W_*       write address / write data channels
//   M_AXI_B_*                    write response channel
//   M_AXI_AR_* / M_AXI_R_*       read address / read data channels
// -----------------------------------------------------------------------------
module axi_lite_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AW_ADDR,
  output logic [2:0]                      M_AXI_AW_PROT,
  output logic                            M_AXI_AW_VALID,
  input  logic                            M_AXI_AW_READY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_W_DATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_W_STRB,
  output logic                            M_AXI_W_VALID,
  input  logic                            M_AXI_W_READY,

  input  logic [1:0]                      M_AXI_B_RESP,
  input  logic                            M_AXI_B_VALID,
  output logic                            M_AXI_B_READY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AR_ADDR,
  output logic [2:0]                      M_AXI_AR_PROT,
  output logic                            M_AXI_AR_VALID,
  input  logic                            M_AXI_AR_READY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_R_DATA,
  input  logic [1:0]                      M_AXI_R_RESP,
  input  logic                            M_AXI_R_VALID,
  output logic                            M_AXI_R_READY
);

  localparam int STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_t;

  state_t                        state;
  state_t                        state_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]         wstrb_q;

  logic                          aw_done;
  logic                          w_done;
  logic                          aw_done_next;
  logic                          w_done_next;

  logic                          cmd_accept;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          b_hs;
  logic                          ar_hs;
  logic                          r_hs;

  // Every AXI output below is a function of registered state only, so there
  // is no combinational path from an AXI input to an AXI output. The write
  // VALIDs are cleared by their own done flags so AW and W retire
  // independently while the FSM stays in WADDR.
  assign cmd_ready      = (state == ST_IDLE);
  assign cmd_accept     = cmd_valid && cmd_ready;

  assign M_AXI_AW_VALID = (state == ST_WADDR) && !aw_done;
  assign M_AXI_W_VALID  = (state == ST_WADDR) && !w_done;
  assign M_AXI_B_READY  = (state == ST_WRESP);
  assign M_AXI_AR_VALID = (state == ST_RADDR);
  assign M_AXI_R_READY  = (state == ST_RDATA);

  assign M_AXI_AW_ADDR  = addr_q;
  assign M_AXI_AR_ADDR  = addr_q;
  assign M_AXI_W_DATA   = wdata_q;
  assign M_AXI_W_STRB   = wstrb_q;
  assign M_AXI_AW_PROT  = 3'b000;
  assign M_AXI_AR_PROT  = 3'b000;

  assign aw_hs = M_AXI_AW_VALID && M_AXI_AW_READY;
  assign w_hs  = M_AXI_W_VALID  && M_AXI_W_READY;
  assign b_hs  = M_AXI_B_READY  && M_AXI_B_VALID;
  assign ar_hs = M_AXI_AR_VALID && M_AXI_AR_READY;
  assign r_hs  = M_AXI_R_READY  && M_AXI_R_VALID;

  // State register and write-channel done flags. Reset returns to IDLE at
  // once, which drops every VALID/READY and abandons any in-flight transfer.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // Next-state logic. In WADDR the done flags are updated with this cycle's
  // handshakes first, so simultaneous AW and W handshakes move straight on
  // to WRESP in a single edge.
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;

    case (state)
      ST_IDLE: begin
        if (cmd_accept) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_write ? ST_WADDR : ST_RADDR;
        end
      end

      ST_WADDR: begin
        if (aw_hs) begin
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          state_next = ST_WRESP;
        end
      end

      ST_WRESP: begin
        if (b_hs) begin
          state_next = ST_IDLE;
        end
      end

      ST_RADDR: begin
        if (ar_hs) begin
          state_next = ST_RDATA;
        end
      end

      ST_RDATA: begin
        if (r_hs) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command payload is captured only at accept, so it stays stable on the
  // bus for as long as the slave holds off READY.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Response capture. rsp_valid is registered from the final handshake, so
  // it lands in the same cycle the FSM is back in IDLE.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      rsp_valid <= b_hs || r_hs;
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_B_RESP;
      end else if (r_hs) begin
        rsp_rdata <= M_AXI_R_DATA;
        rsp_resp  <= M_AXI_R_RESP;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_if
//
// Self-checking bench for axi_lite_master_if. A behavioural 4-register
// AXI4-Lite slave with programmable READY/response delays answers the master.
// Expected results (read data, response code, completion latency) come from
// a simple register-array reference model and latency formula kept in the
// stimulus task; the slave itself checks channel payloads and AXI rules.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_if;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst_n;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic [AW-1:0] aw_addr;
  logic [2:0]    aw_prot;
  logic          aw_valid;
  logic          aw_ready;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          w_valid;
  logic          w_ready;
  logic [1:0]    b_resp;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] ar_addr;
  logic [2:0]    ar_prot;
  logic          ar_valid;
  logic          ar_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_valid;
  logic          r_ready;

  int n_checks;
  int n_errors;

  axi_lite_master_if #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .M_AXI_AW_ADDR (aw_addr),
    .M_AXI_AW_PROT (aw_prot),
    .M_AXI_AW_VALID(aw_valid),
    .M_AXI_AW_READY(aw_ready),
    .M_AXI_W_DATA  (w_data),
    .M_AXI_W_STRB  (w_strb),
    .M_AXI_W_VALID (w_valid),
    .M_AXI_W_READY (w_ready),
    .M_AXI_B_RESP  (b_resp),
    .M_AXI_B_VALID (b_valid),
    .M_AXI_B_READY (b_ready),
    .M_AXI_AR_ADDR (ar_addr),
    .M_AXI_AR_PROT (ar_prot),
    .M_AXI_AR_VALID(ar_valid),
    .M_AXI_AR_READY(ar_ready),
    .M_AXI_R_DATA  (r_data),
    .M_AXI_R_RESP  (r_resp),
    .M_AXI_R_VALID (r_valid),
    .M_AXI_R_READY (r_ready)
  );

  // 10-unit clock; all bench activity happens on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected commands in issue order; the slave checks the bus against the
  // head entry and retires it when the response handshake completes.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  logic [DW-1:0] ref_regs [4];
  logic [DW-1:0] slv_regs [4];

  int            cfg_d_aw, cfg_d_w, cfg_d_b, cfg_d_ar, cfg_d_r;
  logic [1:0]    cfg_resp;

  // Slave-side bookkeeping.
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic          aw_got, w_got, ar_got;
  logic          aw_seen, w_seen, ar_seen;
  logic          b_ready_prev, r_ready_prev;
  logic [AW-1:0] cap_aw_addr, cap_ar_addr;
  logic [DW-1:0] cap_w_data;
  logic [SW-1:0] cap_w_strb;

  // Behavioural slave, evaluated on the falling edge. A READY raised here is
  // seen by the DUT on the next rising edge, so READY still set at the
  // following falling edge means that handshake has completed.
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
      b_valid = 1'b0; r_valid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
      b_ready_prev = 1'b0; r_ready_prev = 1'b0;
    end else begin
      if (exp_q.size() > 0) cur = exp_q[0];

      if (b_valid && b_ready_prev) begin
        b_valid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (r_valid && r_ready_prev) begin
        r_valid = 1'b0;
        r_data  = $urandom();
        ar_got = 1'b0; ar_cnt = 0; r_cnt = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end

      if (aw_ready) begin
        aw_ready = 1'b0; aw_got = 1'b1; aw_seen = 1'b0;
        checkOutput("aw_valid_clear", aw_valid, 1'b0);
      end else begin
        if (aw_seen) checkOutput("aw_valid_hold", aw_valid, 1'b1);
        if (aw_valid && !aw_got) begin
          aw_seen = 1'b1;
          if (exp_q.size() == 0 || !cur.wr) checkOutput("aw_unexpected", aw_valid, 1'b0);
          else checkOutput("aw_addr", aw_addr, cur.addr);
          if (aw_cnt >= cfg_d_aw) begin aw_ready = 1'b1; cap_aw_addr = aw_addr; end
          else aw_cnt++;
        end
      end

      if (w_ready) begin
        w_ready = 1'b0; w_got = 1'b1; w_seen = 1'b0;
        checkOutput("w_valid_clear", w_valid, 1'b0);
      end else begin
        if (w_seen) checkOutput("w_valid_hold", w_valid, 1'b1);
        if (w_valid && !w_got) begin
          w_seen = 1'b1;
          if (exp_q.size() == 0 || !cur.wr) checkOutput("w_unexpected", w_valid, 1'b0);
          else begin
            checkOutput("w_data", w_data, cur.wdata);
            checkOutput("w_strb", w_strb, cur.wstrb);
          end
          if (w_cnt >= cfg_d_w) begin
            w_ready = 1'b1; cap_w_data = w_data; cap_w_strb = w_strb;
          end else w_cnt++;
        end
      end

      if (aw_got && w_got && !b_valid) begin
        if (b_cnt >= cfg_d_b) begin
          for (int i = 0; i < SW; i++)
            if (cap_w_strb[i]) slv_regs[cap_aw_addr[3:2]][8*i +: 8] = cap_w_data[8*i +: 8];
          b_valid = 1'b1;
          b_resp  = cfg_resp;
        end else b_cnt++;
      end

      if (ar_ready) begin
        ar_ready = 1'b0; ar_got = 1'b1; ar_seen = 1'b0;
        checkOutput("ar_valid_clear", ar_valid, 1'b0);
      end else begin
        if (ar_seen) checkOutput("ar_valid_hold", ar_valid, 1'b1);
        if (ar_valid && !ar_got) begin
          ar_seen = 1'b1;
          if (exp_q.size() == 0 || cur.wr) checkOutput("ar_unexpected", ar_valid, 1'b0);
          else checkOutput("ar_addr", ar_addr, cur.addr);
          if (ar_cnt >= cfg_d_ar) begin ar_ready = 1'b1; cap_ar_addr = ar_addr; end
          else ar_cnt++;
        end
      end

      if (ar_got && !r_valid) begin
        if (r_cnt >= cfg_d_r) begin
          r_valid = 1'b1;
          r_data  = slv_regs[cap_ar_addr[3:2]];
          r_resp  = cfg_resp;
        end else r_cnt++;
      end

      // Response READYs only once the matching request side is finished,
      // and never a write VALID alongside a read VALID.
      checkOutput("b_ready_window", b_ready, aw_got && w_got);
      checkOutput("r_ready_window", r_ready, ar_got);
      checkOutput("valid_overlap", (aw_valid | w_valid) & ar_valid, 1'b0);

      b_ready_prev = b_ready;
      r_ready_prev = r_ready;
    end
  end

  // Issues one command with the given slave timing and checks the response
  // against the register model and the expected completion latency.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                               input int d_a, input int d_w, input int d_rsp,
                               input logic [1:0] resp);
    int            lat;
    int            exp_lat;
    int            n;
    logic [DW-1:0] exp_rdata;

    cfg_d_aw = d_a; cfg_d_ar = d_a; cfg_d_w = d_w;
    cfg_d_b = d_rsp; cfg_d_r = d_rsp; cfg_resp = resp;
    exp_q.push_back('{wr, addr, wdata, wstrb});

    if (wr) begin
      for (int i = 0; i < SW; i++)
        if (wstrb[i]) ref_regs[addr[3:2]][8*i +: 8] = wdata[8*i +: 8];
      exp_rdata = '0;
      exp_lat   = 3 + ((d_a > d_w) ? d_a : d_w) + d_rsp;
    end else begin
      exp_rdata = ref_regs[addr[3:2]];
      exp_lat   = 3 + d_a + d_rsp;
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_wstrb = wstrb;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept", cmd_ready, 1'b1);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmd_write = $urandom_range(0, 1); cmd_addr = $urandom();
        cmd_wdata = $urandom(); cmd_wstrb = $urandom();
      end
      if (lat == 2) cmd_valid = 1'b0;
      if (!rsp_valid) checkOutput("cmd_ready_busy", cmd_ready, 1'b0);
    end while (!rsp_valid && lat < 64);
    cmd_valid = 1'b0;

    checkOutput("rsp_latency", lat, exp_lat);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_resp", rsp_resp, resp);
    checkOutput("cmd_ready_at_rsp", cmd_ready, 1'b1);
    @(negedge clk);
    checkOutput("rsp_one_cycle", rsp_valid, 1'b0);
  endtask

  // cmd_valid held high across a write then a read: the read must be
  // accepted in the cycle the write's rsp_valid pulses.
  task automatic backToBack();
    int            lat;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;

    wd = $urandom();
    cfg_d_aw = 1; cfg_d_w = 1; cfg_d_b = 0; cfg_d_ar = 1; cfg_d_r = 0; cfg_resp = 2'b00;
    exp_q.push_back('{1'b1, 4'h0, wd, 4'hF});
    exp_q.push_back('{1'b0, 4'hC, 32'h0, 4'h0});
    ref_regs[0] = wd;
    exp_rd = ref_regs[3];

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = wd; cmd_wstrb = 4'hF;
    checkOutput("b2b_first_ready", cmd_ready, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin cmd_write = 1'b0; cmd_addr = 4'hC; end
      if (!rsp_valid) checkOutput("b2b_busy", cmd_ready, 1'b0);
    end while (!rsp_valid && lat < 64);
    checkOutput("b2b_wr_latency", lat, 4);
    checkOutput("b2b_wr_resp", rsp_resp, 2'b00);
    checkOutput("b2b_wr_rdata", rsp_rdata, 32'h0);
    checkOutput("b2b_ready_at_rsp", cmd_ready, 1'b1);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
      if (!rsp_valid) checkOutput("b2b_rd_busy", cmd_ready, 1'b0);
    end while (!rsp_valid && lat < 64);
    cmd_valid = 1'b0;
    checkOutput("b2b_rd_latency", lat, 4);
    checkOutput("b2b_rd_rdata", rsp_rdata, exp_rd);
    @(negedge clk);
  endtask

  // Asynchronous reset while AR_VALID is waiting for a slow slave.
  task automatic resetMidRead();
    cfg_d_ar = 6; cfg_d_r = 0; cfg_resp = 2'b00;
    exp_q.push_back('{1'b0, 4'h8, 32'h0, 4'h0});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("ar_valid_pre_reset", ar_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("ar_valid_async_drop", ar_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_rsp_in_reset", rsp_valid, 1'b0);
    end
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", cmd_ready, 1'b1);
    checkOutput("no_rsp_after_reset", rsp_valid, 1'b0);
  endtask

  // Hard time limit in case anything stalls outside a bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = 2'b00; r_valid = 1'b0; r_resp = 2'b00; r_data = '0;
    cfg_d_aw = 1; cfg_d_w = 1; cfg_d_b = 0; cfg_d_ar = 1; cfg_d_r = 0; cfg_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ref_regs[i] = i;
      slv_regs[i] = i;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_aw_valid", aw_valid, 1'b0);
    checkOutput("rst_w_valid", w_valid, 1'b0);
    checkOutput("rst_ar_valid", ar_valid, 1'b0);
    checkOutput("rst_b_ready", b_ready, 1'b0);
    checkOutput("rst_r_ready", r_ready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_resp", rsp_resp, 2'b00);
    checkOutput("rst_aw_addr", aw_addr, 4'h0);
    checkOutput("rst_ar_addr", ar_addr, 4'h0);
    checkOutput("rst_w_data", w_data, 32'h0);
    checkOutput("rst_w_strb", w_strb, 4'h0);
    checkOutput("aw_prot", aw_prot, 3'b000);
    checkOutput("ar_prot", ar_prot, 3'b000);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_release", cmd_ready, 1'b1);

    $display("[TB] basic write/read with nominal slave timing");
    applyStimulus(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 1, 1, 0, 2'b00);
    applyStimulus(1'b0, 4'h4, 32'h0, 4'h0, 1, 0, 0, 2'b00);
    applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, 1, 0, 0, 2'b00);

    $display("[TB] skewed AW/W ready");
    applyStimulus(1'b1, 4'hC, 32'hA5A5_0F0F, 4'hF, 3, 0, 0, 2'b00);
    applyStimulus(1'b1, 4'hC, 32'h1357_9BDF, 4'h5, 0, 3, 0, 2'b00);
    applyStimulus(1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 2'b00);

    $display("[TB] error responses");
    applyStimulus(1'b1, 4'h0, 32'h12345678, 4'hF, 1, 1, 0, 2'b10);
    applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 1, 0, 0, 2'b11);

    $display("[TB] back-to-back commands");
    backToBack();

    $display("[TB] reset during read address phase");
    resetMidRead();
    applyStimulus(1'b0, 4'h8, 32'h0, 4'h0, 1, 0, 0, 2'b00);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), 2'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
